// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin arbitrated mux.
// No logic; latency and backpressure are properties of the modules importing it.
// Datapath default width matches the consumer bus.
package rr_arb_pkg;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant, encoded index and next pointer.
// Latency: purely combinational.
// Backpressure: en low forces an all-zero grant.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx,
    output logic [SELW-1:0] next_ptr
);

    logic            found;
    int              c;
    logic [SELW-1:0] cs;

    // Scan starting at ptr and wrapping; the first requester wins.
    always_comb begin
        grant    = '0;
        idx      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        c        = 0;
        cs       = '0;
        for (int k = 0; k < N; k++) begin
            c  = (int'(ptr) + k) % N;
            cs = SELW'(c);
            if (en && !found && req[cs]) begin
                found     = 1'b1;
                grant[cs] = 1'b1;
                idx       = cs;
                next_ptr  = (c == N - 1) ? '0 : SELW'(c + 1);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrated mux with a registered valid/ready output; RR_ARB_MUX_FIXED_PRIO_EN selects fixed priority.
// Latency: one cycle from accepted input to out_valid.
// Backpressure: in_ready drops while the output register is full and not draining.
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N     = 4,
    localparam int SELW  = clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    logic              load_en;
    logic              xfer;
    logic [N-1:0]      grant;
    logic [SELW-1:0]   grant_idx;
    logic [SELW-1:0]   next_ptr;
    logic [SELW-1:0]   ptr;
    logic [WIDTH-1:0]  sel_data;

    // Gating with reset_n keeps in_ready low while reset is held.
    assign load_en = (!out_valid || out_ready) && reset_n;

    rr_arbiter #(.N(N)) u_arb (
        .req      (in_valid),
        .ptr      (ptr),
        .en       (load_en),
        .grant    (grant),
        .idx      (grant_idx),
        .next_ptr (next_ptr)
    );

    assign in_ready = grant;
    assign xfer     = |grant;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    assign ptr = '0;
`else
    // Pointer moves only on a real transfer, never on idle or stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= next_ptr;
        end
    end
`endif

endmodule
